// File: rtl/pm_fetch_unit.sv
// rtl/pm_fetch_unit.sv - program-memory instruction fetch with 2-entry instruction queue and branch redirect
module pm_fetch_unit #(
    parameter int PMA_SIZE = 16,
    parameter int PMD_SIZE = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                fetch_en,
    input  logic                br_taken,
    input  logic [PMA_SIZE-1:0] br_addr,
    input  logic                dec_stall,
    output logic                ps_pm_cslt,
    output logic                ps_pm_wrb,
    output logic [PMA_SIZE-1:0] ps_pm_add,
    input  logic [PMD_SIZE-1:0] pm_ps_op,
    output logic                inst_vld,
    output logic [PMD_SIZE-1:0] inst,
    output logic [PMA_SIZE-1:0] inst_pc,
    output logic                fetch_busy
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state_q, state_d;
    logic [PMA_SIZE-1:0]   pc_q, pc_d;
    logic [PMA_SIZE-1:0]   resp_pc_q, resp_pc_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            count_q, count_d;
    logic [PMD_SIZE-1:0]   head_data_q, head_data_d, tail_data_q, tail_data_d;
    logic [PMA_SIZE-1:0]   head_pc_q, head_pc_d, tail_pc_q, tail_pc_d;

    logic                  pop;
    logic                  push;
    logic                  issue;
    logic [2:0]            occ;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            resp_pc_q   <= '0;
            inflight_q  <= 1'b0;
            count_q     <= 2'd0;
            head_data_q <= '0;
            tail_data_q <= '0;
            head_pc_q   <= '0;
            tail_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            resp_pc_q   <= resp_pc_d;
            inflight_q  <= inflight_d;
            count_q     <= count_d;
            head_data_q <= head_data_d;
            tail_data_q <= tail_data_d;
            head_pc_q   <= head_pc_d;
            tail_pc_q   <= tail_pc_d;
        end
    end

    always_comb begin
        state_d     = fetch_en ? RUN : IDLE;
        pc_d        = pc_q;
        resp_pc_d   = resp_pc_q;
        count_d     = count_q;
        head_data_d = head_data_q;
        tail_data_d = tail_data_q;
        head_pc_d   = head_pc_q;
        tail_pc_d   = tail_pc_q;

        pop  = (count_q != 2'd0) & ~dec_stall;
        push = inflight_q;
        // Slots already promised: queued words plus the read still in flight.
        occ   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue = (state_q == RUN) & ~br_taken & (occ < 3'd2);
        inflight_d = issue;

        if (br_taken) begin
            pc_d = br_addr;
        end else if (issue) begin
            pc_d      = pc_q + {{(PMA_SIZE-1){1'b0}}, 1'b1};
            resp_pc_d = pc_q;
        end

        // A branch discards the queue and any word landing on the same edge.
        if (br_taken) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_data_d = pm_ps_op;
                        head_pc_d   = resp_pc_q;
                    end else begin
                        tail_data_d = pm_ps_op;
                        tail_pc_d   = resp_pc_q;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_data_d = tail_data_q;
                    head_pc_d   = tail_pc_q;
                    count_d     = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_data_d = pm_ps_op;
                        head_pc_d   = resp_pc_q;
                    end else begin
                        head_data_d = tail_data_q;
                        head_pc_d   = tail_pc_q;
                        tail_data_d = pm_ps_op;
                        tail_pc_d   = resp_pc_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ps_pm_cslt = issue;
    assign ps_pm_wrb  = 1'b0;
    assign ps_pm_add  = pc_q;
    assign inst_vld   = (count_q != 2'd0);
    assign inst       = head_data_q;
    assign inst_pc    = head_pc_q;
    assign fetch_busy = (state_q == RUN) | inflight_q;

endmodule

// File: tb/tb_pm_fetch_unit.sv
// tb/tb_pm_fetch_unit.sv - directed self-checking bench for pm_fetch_unit
module tb_pm_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic        br_taken;
    logic [15:0] br_addr;
    logic        dec_stall;
    logic        ps_pm_cslt;
    logic        ps_pm_wrb;
    logic [15:0] ps_pm_add;
    logic [31:0] pm_ps_op = 32'h0;
    logic        inst_vld;
    logic [31:0] inst;
    logic [15:0] inst_pc;
    logic        fetch_busy;

    int n_chk  = 0;
    int n_fail = 0;

    pm_fetch_unit #(.PMA_SIZE(16), .PMD_SIZE(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_en   (fetch_en),
        .br_taken   (br_taken),
        .br_addr    (br_addr),
        .dec_stall  (dec_stall),
        .ps_pm_cslt (ps_pm_cslt),
        .ps_pm_wrb  (ps_pm_wrb),
        .ps_pm_add  (ps_pm_add),
        .pm_ps_op   (pm_ps_op),
        .inst_vld   (inst_vld),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .fetch_busy (fetch_busy)
    );

    always #5 clk = ~clk;

    // Synchronous program memory: word at address A is {~A, A}.
    always @(posedge clk) begin
        if (ps_pm_cslt) pm_ps_op <= {~ps_pm_add, ps_pm_add};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic fe, input logic st, input logic br, input logic [15:0] ba);
        @(negedge clk);
        fetch_en  = fe;
        dec_stall = st;
        br_taken  = br;
        br_addr   = ba;
        #1;
        check("wrb", 32'(ps_pm_wrb), 32'h0);
    endtask

    task automatic chk_issue(input string tag, input logic c, input logic [15:0] a);
        check({tag, "_cslt"}, 32'(ps_pm_cslt), 32'(c));
        if (c) check({tag, "_add"}, 32'(ps_pm_add), 32'(a));
    endtask

    task automatic chk_head(input string tag, input logic v, input logic [15:0] pc);
        logic [15:0] npc;
        npc = ~pc;
        check({tag, "_vld"}, 32'(inst_vld), 32'(v));
        if (v) begin
            check({tag, "_pc"}, 32'(inst_pc), 32'(pc));
            check({tag, "_inst"}, inst, {npc, pc});
        end
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_cslt"}, 32'(ps_pm_cslt), 32'h0);
        check({tag, "_add"}, 32'(ps_pm_add), 32'h0);
        check({tag, "_wrb"}, 32'(ps_pm_wrb), 32'h0);
        check({tag, "_vld"}, 32'(inst_vld), 32'h0);
        check({tag, "_inst"}, inst, 32'h0);
        check({tag, "_pc"}, 32'(inst_pc), 32'h0);
        check({tag, "_busy"}, 32'(fetch_busy), 32'h0);
    endtask

    initial begin
        reset = 1'b1; fetch_en = 1'b0; br_taken = 1'b0; br_addr = 16'h0; dec_stall = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset("rst");
        reset = 1'b0;

        // T1: streaming from address 0
        cyc(1, 0, 0, 16'h0);   chk_issue("t1c0", 0, 16'h0); check("t1c0_busy", 32'(fetch_busy), 32'h0);
        cyc(1, 0, 0, 16'h0);   chk_issue("t1c1", 1, 16'h0000); chk_head("t1c1", 0, 16'h0);
        check("t1c1_busy", 32'(fetch_busy), 32'h1);
        cyc(1, 0, 0, 16'h0);   chk_issue("t1c2", 1, 16'h0001); chk_head("t1c2", 0, 16'h0);
        cyc(1, 0, 0, 16'h0);   chk_issue("t1c3", 1, 16'h0002); chk_head("t1c3", 1, 16'h0000);
        cyc(1, 0, 0, 16'h0);   chk_issue("t1c4", 1, 16'h0003); chk_head("t1c4", 1, 16'h0001);

        // T2: three stalled cycles with pc 2 at the head
        cyc(1, 1, 0, 16'h0);   chk_issue("t2c5", 0, 16'h0); chk_head("t2c5", 1, 16'h0002);
        cyc(1, 1, 0, 16'h0);   chk_issue("t2c6", 0, 16'h0); chk_head("t2c6", 1, 16'h0002);
        cyc(1, 1, 0, 16'h0);   chk_issue("t2c7", 0, 16'h0); chk_head("t2c7", 1, 16'h0002);
        cyc(1, 0, 0, 16'h0);   chk_issue("t2c8", 1, 16'h0004); chk_head("t2c8", 1, 16'h0002);
        cyc(1, 0, 0, 16'h0);   chk_issue("t2c9", 1, 16'h0005); chk_head("t2c9", 1, 16'h0003);

        // T3: branch while the read of pc 5 is in flight
        cyc(1, 0, 1, 16'h0100); chk_issue("t3c10", 0, 16'h0); chk_head("t3c10", 1, 16'h0004);
        cyc(1, 0, 0, 16'h0);   chk_issue("t3c11", 1, 16'h0100); chk_head("t3c11", 0, 16'h0);
        cyc(1, 0, 0, 16'h0);   chk_issue("t3c12", 1, 16'h0101); chk_head("t3c12", 0, 16'h0);
        cyc(1, 0, 0, 16'h0);   chk_head("t3c13", 1, 16'h0100);

        // T4: wrap across the top of the address space
        cyc(1, 0, 1, 16'hFFFE); chk_issue("t4c14", 0, 16'h0); chk_head("t4c14", 1, 16'h0101);
        cyc(1, 0, 0, 16'h0);   chk_issue("t4c15", 1, 16'hFFFE); chk_head("t4c15", 0, 16'h0);
        cyc(1, 0, 0, 16'h0);   chk_issue("t4c16", 1, 16'hFFFF); chk_head("t4c16", 0, 16'h0);
        cyc(1, 0, 0, 16'h0);   chk_issue("t4c17", 1, 16'h0000); chk_head("t4c17", 1, 16'hFFFE);
        cyc(1, 0, 0, 16'h0);   chk_head("t4c18", 1, 16'hFFFF);
        cyc(1, 0, 0, 16'h0);   chk_head("t4c19", 1, 16'h0000);
        cyc(1, 0, 0, 16'h0);   chk_head("t4c20", 1, 16'h0001);

        // T5: asynchronous reset between edges
        #2 reset = 1'b1;
        #1 chk_reset("t5a");
        @(negedge clk);
        chk_reset("t5b");
        reset = 1'b0;
        #1 chk_issue("t5r0", 0, 16'h0);
        cyc(1, 0, 0, 16'h0);   chk_issue("t5r1", 1, 16'h0000);

        // T6: stop fetching with a read in flight, hold the queue with a stall
        cyc(0, 0, 0, 16'h0);   chk_issue("t6r2", 1, 16'h0001); chk_head("t6r2", 0, 16'h0);
        cyc(0, 1, 0, 16'h0);   chk_issue("t6r3", 0, 16'h0); chk_head("t6r3", 1, 16'h0000);
        check("t6r3_busy", 32'(fetch_busy), 32'h1);
        cyc(0, 1, 0, 16'h0);   chk_issue("t6r4", 0, 16'h0); chk_head("t6r4", 1, 16'h0000);
        check("t6r4_busy", 32'(fetch_busy), 32'h0);
        cyc(0, 1, 0, 16'h0);   chk_issue("t6r5", 0, 16'h0); chk_head("t6r5", 1, 16'h0000);
        cyc(0, 0, 0, 16'h0);   chk_issue("t6r6", 0, 16'h0); chk_head("t6r6", 1, 16'h0000);
        cyc(0, 0, 0, 16'h0);   chk_issue("t6r7", 0, 16'h0); chk_head("t6r7", 1, 16'h0001);
        cyc(0, 0, 0, 16'h0);   chk_head("t6r8", 0, 16'h0);
        check("t6r8_busy", 32'(fetch_busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
